// File: rtl/stream_pkg.sv
// Shared constants and width helpers for the stream_merge fan-in.
package stream_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Channel-index width; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Per-channel FIFO with a registered write-ready derived from the next count.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_stb,
    output logic             wr_ack,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_en,
    output logic             empty,
    output logic             full
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic             wr, rd;

    // A write needs the registered ready, so a full FIFO refuses even when it is read this cycle.
    assign wr      = wr_stb && wr_ack;
    assign rd      = rd_en && !empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({wr, rd})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_ack <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            wr_ack <= (count_nxt != FULL_CNT);
        end
    end

endmodule

// File: rtl/stream_merge.sv
// N-to-1 buffered stream merger with round-robin arbitration and sticky exception.
// STREAM_MERGE_TAG_EN: prepend the granted channel index to output_data.
module stream_merge
    import stream_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] input_data,
    input  logic [CHANNELS-1:0]       input_stb,
    output logic [CHANNELS-1:0]       input_ack,
`ifdef STREAM_MERGE_TAG_EN
    output logic [WIDTH+chan_w(CHANNELS)-1:0] output_data,
`else
    output logic [WIDTH-1:0]          output_data,
`endif
    output logic                      output_stb,
    input  logic                      output_ack,
    input  logic [CHANNELS-1:0]       exception_in,
    output logic                      exception
);

    localparam int CW = chan_w(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] fifo_data;
    logic [CHANNELS-1:0]            empty, full, ready, rd_en;
    logic [CW-1:0]                  last_grant, grant;
    logic                           grant_valid, load;
    logic [CW:0]                    cand;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_data (input_data[i*WIDTH +: WIDTH]),
            .wr_stb  (input_stb[i]),
            .wr_ack  (ready[i]),
            .rd_data (fifo_data[i]),
            .rd_en   (rd_en[i]),
            .empty   (empty[i]),
            .full    (full[i])
        );
        assign input_ack[i] = ready[i] && !full[i];
    end

    assign load = !output_stb || output_ack;

    // Search from last_grant+1 with wrap; first non-empty channel wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int off = 1; off <= CHANNELS; off++) begin
            cand = {1'b0, last_grant} + (CW + 1)'(off);
            if (cand >= (CW + 1)'(CHANNELS)) cand = cand - (CW + 1)'(CHANNELS);
            if (!grant_valid && !empty[cand[CW-1:0]]) begin
                grant_valid = 1'b1;
                grant       = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        rd_en = '0;
        if (load && grant_valid) rd_en[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            output_stb  <= 1'b0;
            output_data <= '0;
            last_grant  <= CW'(CHANNELS - 1);
        end else if (load) begin
            output_stb <= grant_valid;
            if (grant_valid) begin
`ifdef STREAM_MERGE_TAG_EN
                output_data <= {grant, fifo_data[grant]};
`else
                output_data <= fifo_data[grant];
`endif
                last_grant  <= grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) exception <= 1'b0;
        else                   exception <= exception | (|exception_in);
    end

endmodule

// File: tb/tb_stream_merge.sv
// Directed self-checking bench for stream_merge (CHANNELS=4, WIDTH=32, DEPTH=4).
module tb_stream_merge;

    localparam int CH = 4;
    localparam int W  = 32;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*W-1:0] input_data;
    logic [CH-1:0]   input_stb;
    logic [CH-1:0]   input_ack;
`ifdef STREAM_MERGE_TAG_EN
    logic [W+1:0]    output_data;
`else
    logic [W-1:0]    output_data;
`endif
    logic            output_stb;
    logic            output_ack;
    logic [CH-1:0]   exception_in;
    logic            exception;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_merge #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_data   (input_data),
        .input_stb    (input_stb),
        .input_ack    (input_ack),
        .output_data  (output_data),
        .output_stb   (output_stb),
        .output_ack   (output_ack),
        .exception_in (exception_in),
        .exception    (exception)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        int          accepted;
        int          stale;
        logic [31:0] word;
        logic [31:0] exp;

        rst          = 1'b0;
        input_stb    = '1;
        input_data   = '0;
        output_ack   = 1'b0;
        exception_in = '0;

        // Reset held 3 cycles with all producers asserting stb
        repeat (3) step();
        check("rst_ostb", output_stb, 0);
        check("rst_iack", input_ack, 0);
        check("rst_exc", exception, 0);
        check("rst_odata", output_data, 0);
        rst       = 1'b1;
        input_stb = '0;
        step();
        check("rel_iack", input_ack, 4'hF);
        check("rel_ostb", output_stb, 0);

        // Single word on ch2: visible two edges after issue
        output_ack          = 1'b1;
        input_data[2*W +: W] = 32'hDEADBEEF;
        input_stb           = 4'b0100;
        step();
        input_stb = '0;
        check("one_lat1", output_stb, 0);
        step();
        check("one_stb", output_stb, 1);
        check("one_data", output_data[W-1:0], 32'hDEADBEEF);
`ifdef STREAM_MERGE_TAG_EN
        check("one_tag", output_data[W+1:W], 2);
`endif
        step();
        check("one_done", output_stb, 0);

        // Fairness: 4 words per channel, drained in 0,1,2,3 order
        do_reset();
        output_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < CH; c++) input_data[c*W +: W] = 32'(c * 256 + k);
            input_stb = '1;
            step();
        end
        input_stb  = '0;
        output_ack = 1'b1;
        for (int j = 0; j < 16; j++) begin
            exp = 32'((j % 4) * 256 + j / 4);
            check($sformatf("fair_stb%0d", j), output_stb, 1);
            check($sformatf("fair_data%0d", j), output_data[W-1:0], exp);
`ifdef STREAM_MERGE_TAG_EN
            check($sformatf("fair_tag%0d", j), output_data[W+1:W], j % 4);
`endif
            step();
        end
        check("fair_empty", output_stb, 0);

        // Backpressure: ch0 streams until its FIFO and the output register fill
        output_ack = 1'b0;
        accepted   = 0;
        word       = 32'hA000_0000;
        input_stb  = 4'b0001;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (!input_ack[0]) break;
            input_data[0 +: W] = word;
            step();
            accepted++;
            word++;
        end
        input_stb = '0;
        check("bp_accepted", accepted, 5);
        check("bp_iack", input_ack, 4'b1110);
        check("bp_stb", output_stb, 1);
        check("bp_hold0", output_data[W-1:0], 32'hA000_0000);
        step();
        step();
        check("bp_hold2", output_data[W-1:0], 32'hA000_0000);
        check("bp_stb2", output_stb, 1);
        output_ack = 1'b1;
        for (int n = 0; n < 5; n++) begin
            check($sformatf("bp_dstb%0d", n), output_stb, 1);
            check($sformatf("bp_data%0d", n), output_data[W-1:0], 32'(32'hA000_0000 + n));
            step();
        end
        check("bp_drained", output_stb, 0);
        check("bp_iack_back", input_ack, 4'hF);

        // Sticky exception from a one-cycle pulse on ch3
        check("exc_pre", exception, 0);
        exception_in = 4'b1000;
        step();
        exception_in = '0;
        check("exc_rise", exception, 1);
        repeat (3) step();
        check("exc_sticky", exception, 1);

        // Reset with FIFOs half full: nothing stale may come out afterwards
        output_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            input_data[1*W +: W] = 32'(32'hBAD1_0000 + k);
            input_data[2*W +: W] = 32'(32'hBAD2_0000 + k);
            input_stb            = 4'b0110;
            step();
        end
        input_stb = '0;
        check("mid_prestb", output_stb, 1);
        rst = 1'b0;
        step();
        check("mid_ostb", output_stb, 0);
        check("mid_iack", input_ack, 0);
        check("mid_exc", exception, 0);
        rst = 1'b1;
        step();
        check("mid_rel_iack", input_ack, 4'hF);
        output_ack = 1'b1;
        stale      = 0;
        repeat (6) begin
            if (output_stb) stale++;
            step();
        end
        check("mid_stale", stale, 0);
        input_data[3*W +: W] = 32'h1234_5678;
        input_stb            = 4'b1000;
        step();
        input_stb = '0;
        step();
        check("mid_fresh_stb", output_stb, 1);
        check("mid_fresh_data", output_data[W-1:0], 32'h1234_5678);
`ifdef STREAM_MERGE_TAG_EN
        check("mid_fresh_tag", output_data[W+1:W], 3);
`endif
        step();
        check("mid_end", output_stb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_merge.md
# stream_merge

Parametrised N-to-1 stream merger for the user design top level. It replaces point-to-point wiring of one process per port with a buffered fan-in. Each of CHANNELS stb/ack input streams feeds its own small FIFO, and a round-robin arbiter drains the FIFOs into one registered stb/ack output. Per-channel exception lines are aggregated into one registered, sticky `exception`.

## Interface
Parameters:
- `CHANNELS`, 4: number of input streams, 2..16.
- `WIDTH`, 32: data width per stream.
- `DEPTH`, 4: per-channel FIFO depth, power of two, 2..64.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-low reset.
- `input_data` in CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `input_stb` in CHANNELS: per-channel valid.
- `input_ack` out CHANNELS: per-channel ready.
- `output_data` out WIDTH (WIDTH+CW with tag, CW = clog2(CHANNELS)): merged word.
- `output_stb` out 1: output word valid.
- `output_ack` in 1: downstream accepts.
- `exception_in` in CHANNELS: per-channel fault lines from producer processes.
- `exception` out 1: sticky OR of all faults.

## Operation
- Transfer rule: a word moves on a rising edge when stb and ack are both high. Without ack, the producer holds stb and data stable.
- Input side:
  - `input_ack[i]` = !full[i].
  - `input_ack[i]` is registered from the FIFO count and is independent of `input_stb`.
  - A full FIFO never accepts a word, even if it is read in the same cycle.
- Output register:
  - Loads when empty or when the current word transfers this edge. This gives full throughput of one word per cycle.
  - Holds `output_data` stable while `output_stb`=1 and `output_ack`=0.
- Arbiter:
  - Round-robin over non-empty FIFOs.
  - Search starts at (last_grant+1) mod CHANNELS and wraps past CHANNELS-1 to 0.
  - last_grant updates only on an actual load.
  - Reset value of last_grant is CHANNELS-1, so channel 0 has first priority.
- FIFO pointers are clog2(DEPTH) bits and wrap naturally. Count is clog2(DEPTH)+1 bits.
- Exception:
  - `exception` <= `exception` | (|`exception_in`).
  - Cleared only by reset.
- Reset:
  - All FIFOs empty and all contents discarded.
  - `output_stb`=0, `output_data`=0, `exception`=0, all `input_ack`=0 during reset, last_grant=CHANNELS-1.
  - Reset asserted mid-transfer drops the held word.

## Timing
- `input_ack` is high on the first edge after `rst` deasserts.
- Minimum latency is 2 edges:
  - Edge E: input accepted.
  - Edge E+1: output register loaded; `output_stb` high after E+1.
- Simultaneous FIFO write and read at count 1 leaves the count unchanged and the ordering intact.
- Simultaneous write to an empty FIFO and arbitration in the same cycle: the new word is not visible until the next cycle.
- Fairness: with all channels backlogged and `output_ack`=1, grant order is 0,1,…,CHANNELS-1,0,… with no channel skipped.
- Maximum wait for a backlogged channel is CHANNELS-1 grants.
- `exception` rises one edge after any `exception_in` bit.

## Configuration
- Macro: `STREAM_MERGE_TAG_EN`.
- Defined:
  - `output_data` is WIDTH+CW bits.
  - The upper CW bits carry the granted channel index, registered with the data.
- Undefined: `output_data` is WIDTH bits, no tag logic.

## Structure
- Package `stream_pkg`:
  - clog2 function.
  - Channel-index width constant derivation.
  - Reset-level constant RST_ACTIVE=1'b0.
- Sub-module `stream_fifo`:
  - Parameters WIDTH and DEPTH.
  - Ports: write stb/ack, read data, read-enable, empty/full.
  - Instantiated CHANNELS times via generate.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with all `input_stb`=1. Required: `output_stb`=0, `input_ack`=0, `exception`=0. One edge after release, `input_ack`=all-ones.
- Single word: ch2 sends 0xDEADBEEF with `output_ack`=1. Required: `output_stb` high 2 edges later with data 0xDEADBEEF (tag 2 when `STREAM_MERGE_TAG_EN` is defined).
- Fairness: CHANNELS=4, each channel preloaded with 4 words, `output_ack`=1. Required: 16 consecutive outputs in channel order 0,1,2,3 repeated, per-channel order preserved.
- Backpressure: DEPTH=4, `output_ack`=0, ch0 streams continuously. Required:
  - `input_ack[0]` falls after 4 accepted words plus 1 held in the output register.
  - Held `output_data` stays stable.
  - Releasing ack drains all 5 words in order.
- Exception: pulse `exception_in[3]` for 1 cycle. Required: `exception`=1 from the next edge until `rst` is asserted.
- Reset mid-stream: assert `rst` with FIFOs half full. Required: no stale words emitted after release.
